apb_multi_slave_master: RTL and testbench

- Parametrised APB system master, the next generation of the single-slave APB master/GPIO pairing.
- Accepts single read/write requests on a valid/ready request port and decodes the target slave from address bits.
- Drives the APB SETUP/ACCESS sequence to one of NUM_SLV slaves and returns data and error status on a one-cycle response strobe.
- Adds features the previous generation lacks: wait-state timeout, decode-error reporting and a saturating error counter.

---
 rtl/apb_multi_slave_master.sv | 227 ++++++++++++++++++++++
 tb/tb_apb_multi_slave_master.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_multi_slave_master.sv
// Purpose : APB system master; one valid/ready request at a time, slave picked by address field.
// Latency : response strobe in the 3rd cycle after accept (plus one per wait state); decode error in the 1st.
// Backpress: req_ready is high only in IDLE; one transfer in flight, no pipelining.
//
// Ports
//   PCLK, PRESET                : clock, synchronous active-high reset
//   req_valid/req_ready         : request handshake; req_write/req_addr/req_wdata describe the transfer
//   rsp_valid                   : one-cycle completion strobe; rsp_rdata/rsp_err hold until the next one
//   err_count                   : saturating count of responses with rsp_err set
//   PSEL..PWDATA                : APB master outputs (all registered)
//   PRDATA/PREADY/PSLVERR       : per-slave APB returns, slave i at slice i
module apb_multi_slave_master #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int NUM_SLV = 4,
  parameter int SEL_LSB = 12,
  parameter int TIMEOUT = 16
) (
  input  logic                        PCLK,
  input  logic                        PRESET,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic                        req_write,
  input  logic [ADDR_W-1:0]           req_addr,
  input  logic [DATA_W-1:0]           req_wdata,
  output logic                        rsp_valid,
  output logic [DATA_W-1:0]           rsp_rdata,
  output logic                        rsp_err,
  output logic [7:0]                  err_count,
  output logic [NUM_SLV-1:0]          PSEL,
  output logic                        PENABLE,
  output logic [ADDR_W-1:0]           PADDR,
  output logic                        PWRITE,
  output logic [DATA_W-1:0]           PWDATA,
  input  logic [NUM_SLV*DATA_W-1:0]   PRDATA,
  input  logic [NUM_SLV-1:0]          PREADY,
  input  logic [NUM_SLV-1:0]          PSLVERR
);

  localparam int SEL_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_DONE
  } state_t;

  state_t              r_state;
  logic                r_req_ready;
  logic                r_rsp_valid;
  logic [DATA_W-1:0]   r_rsp_rdata;
  logic                r_rsp_err;
  logic [7:0]          r_err_count;
  logic [NUM_SLV-1:0]  r_psel;
  logic                r_penable;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_write;
  logic [DATA_W-1:0]   r_wdata;
  logic [SEL_W-1:0]    r_idx;
  logic [CNT_W-1:0]    r_wait_cnt;

  state_t              w_state_nxt;
  logic                w_accept;
  logic [SEL_W-1:0]    w_idx;
  logic                w_dec_err;
  logic [NUM_SLV-1:0]  w_idx_oh;
  logic                w_sel_ready;
  logic                w_sel_err;
  logic [DATA_W-1:0]   w_sel_rdata;
  logic [NUM_SLV-1:0]  w_psel_nxt;
  logic                w_penable_nxt;
  logic                w_req_ready_nxt;
  logic                w_rsp_valid_nxt;
  logic                w_rsp_err_nxt;
  logic [DATA_W-1:0]   w_rsp_rdata_nxt;
  logic [CNT_W-1:0]    w_cnt_nxt;

  assign w_accept  = req_valid & r_req_ready;
  assign w_idx     = req_addr[SEL_LSB +: SEL_W];
  // Only reachable when NUM_SLV is not a power of two (or is 1).
  assign w_dec_err = (int'(w_idx) >= NUM_SLV);

  // One-hot of the incoming index, used to load PSEL on the accept edge.
  always_comb begin
    w_idx_oh = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      w_idx_oh[i] = (w_idx == SEL_W'(i));
    end
  end

  // Mux the selected slave's return signals; other slaves are never looked at.
  always_comb begin
    w_sel_ready = 1'b0;
    w_sel_err   = 1'b0;
    w_sel_rdata = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (r_idx == SEL_W'(i)) begin
        w_sel_ready = PREADY[i];
        w_sel_err   = PSLVERR[i];
        w_sel_rdata = PRDATA[i*DATA_W +: DATA_W];
      end
    end
  end

  // Next-state and next-output logic. Every APB/handshake output is computed
  // here one cycle ahead and registered, so PREADY never reaches PSEL/PENABLE
  // combinationally.
  always_comb begin
    w_state_nxt     = r_state;
    w_psel_nxt      = '0;
    w_penable_nxt   = 1'b0;
    w_req_ready_nxt = 1'b0;
    w_rsp_valid_nxt = 1'b0;
    w_rsp_err_nxt   = 1'b0;
    w_rsp_rdata_nxt = '0;
    w_cnt_nxt       = r_wait_cnt;

    case (r_state)
      ST_IDLE: begin
        w_req_ready_nxt = 1'b1;
        if (w_accept) begin
          w_req_ready_nxt = 1'b0;
          if (w_dec_err) begin
            // No slave is touched; report straight away.
            w_state_nxt     = ST_DONE;
            w_rsp_valid_nxt = 1'b1;
            w_rsp_err_nxt   = 1'b1;
          end else begin
            w_state_nxt = ST_SETUP;
            w_psel_nxt  = w_idx_oh;
          end
        end
      end

      ST_SETUP: begin
        w_state_nxt   = ST_ACCESS;
        w_psel_nxt    = r_psel;
        w_penable_nxt = 1'b1;
        w_cnt_nxt     = '0;
      end

      ST_ACCESS: begin
        if (w_sel_ready) begin
          // Ready takes priority over a timeout expiring in the same cycle.
          w_state_nxt     = ST_DONE;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_err_nxt   = w_sel_err;
          w_rsp_rdata_nxt = r_write ? '0 : w_sel_rdata;
        end else if (r_wait_cnt == CNT_W'(TIMEOUT - 1)) begin
          w_state_nxt     = ST_DONE;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_err_nxt   = 1'b1;
        end else begin
          w_psel_nxt    = r_psel;
          w_penable_nxt = 1'b1;
          w_cnt_nxt     = r_wait_cnt + CNT_W'(1);
        end
      end

      ST_DONE: begin
        w_state_nxt     = ST_IDLE;
        w_req_ready_nxt = 1'b1;
      end

      default: begin
        w_state_nxt     = ST_IDLE;
        w_req_ready_nxt = 1'b1;
      end
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_state     <= ST_IDLE;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_err_count <= '0;
      r_psel      <= '0;
      r_penable   <= 1'b0;
      r_addr      <= '0;
      r_write     <= 1'b0;
      r_wdata     <= '0;
      r_idx       <= '0;
      r_wait_cnt  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_req_ready <= w_req_ready_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_psel      <= w_psel_nxt;
      r_penable   <= w_penable_nxt;
      r_wait_cnt  <= w_cnt_nxt;

      // Transfer attributes stay put from SETUP through ACCESS.
      if (w_accept) begin
        r_addr  <= req_addr;
        r_write <= req_write;
        r_wdata <= req_wdata;
        r_idx   <= w_idx;
      end

      // Response data/status only change when a new response is issued.
      if (w_rsp_valid_nxt) begin
        r_rsp_err   <= w_rsp_err_nxt;
        r_rsp_rdata <= w_rsp_rdata_nxt;
        if (w_rsp_err_nxt && (r_err_count != 8'hFF)) begin
          r_err_count <= r_err_count + 8'd1;
        end
      end
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign err_count = r_err_count;
  assign PSEL      = r_psel;
  assign PENABLE   = r_penable;
  assign PADDR     = r_addr;
  assign PWRITE    = r_write;
  assign PWDATA    = r_wdata;

endmodule

// File: tb/tb_apb_multi_slave_master.sv
// Directed bench for apb_multi_slave_master: a 4-slave instance driven through
// write/read/timeout/slave-error/back-to-back/saturation/reset scenarios, and a
// 3-slave instance used for the decode-error case.
module tb_apb_multi_slave_master;

  logic        PCLK = 1'b0;
  logic        PRESET;

  // 4-slave DUT
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [7:0]  err_count;
  logic [3:0]  PSEL;
  logic        PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA;
  logic [127:0] PRDATA;
  logic [3:0]  PREADY, PSLVERR;

  // 3-slave DUT
  logic        req_valid3, req_ready3;
  logic [31:0] req_addr3;
  logic        rsp_valid3, rsp_err3;
  logic [31:0] rsp_rdata3;
  logic [7:0]  err_count3;
  logic [2:0]  PSEL3;
  logic        PENABLE3, PWRITE3;
  logic [31:0] PADDR3, PWDATA3;

  // Slave models: wait_cfg 0 = PREADY tied high, <0 = never ready,
  // n>0 = ready after n wait states once selected.
  int          wait_cfg [4];
  logic [31:0] rd_val   [4];
  logic [3:0]  err_cfg;
  int          acc_cyc;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 PCLK = ~PCLK;

  always @(posedge PCLK) begin
    if (PENABLE) acc_cyc <= acc_cyc + 1;
    else         acc_cyc <= 0;
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      PRDATA[i*32 +: 32] = rd_val[i];
      if (wait_cfg[i] == 0)     PREADY[i] = 1'b1;
      else if (wait_cfg[i] < 0) PREADY[i] = 1'b0;
      else                      PREADY[i] = PSEL[i] & PENABLE & (acc_cyc >= wait_cfg[i]);
    end
    PSLVERR = err_cfg;
  end

  apb_multi_slave_master #(.NUM_SLV(4)) u_dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .err_count(err_count),
    .PSEL(PSEL), .PENABLE(PENABLE), .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  apb_multi_slave_master #(.NUM_SLV(3)) u_dut3 (
    .PCLK(PCLK), .PRESET(PRESET),
    .req_valid(req_valid3), .req_ready(req_ready3), .req_write(1'b0),
    .req_addr(req_addr3), .req_wdata(32'h0),
    .rsp_valid(rsp_valid3), .rsp_rdata(rsp_rdata3), .rsp_err(rsp_err3), .err_count(err_count3),
    .PSEL(PSEL3), .PENABLE(PENABLE3), .PADDR(PADDR3), .PWRITE(PWRITE3), .PWDATA(PWDATA3),
    .PRDATA({3{32'h5555_AAAA}}), .PREADY(3'b111), .PSLVERR(3'b000)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one request in the current cycle; returns just after the accept edge
  // (i.e. 1st cycle after accept).
  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d);
    chk("req_ready_before_issue", req_ready, 1);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    @(posedge PCLK); #1;
    req_valid = 1'b0;
  endtask

  // Waits for rsp_valid; cyc is the cycle index after accept where it appeared.
  task automatic wait_rsp(input int max, output int cyc);
    cyc = 1;
    while (rsp_valid !== 1'b1 && cyc < max) begin
      @(posedge PCLK); #1;
      cyc++;
    end
    chk("rsp_seen", rsp_valid, 1);
  endtask

  initial begin
    int cyc, pen, nacc, nrsp, last_acc, any_rsp;
    logic was_rdy;
    logic [31:0] b2b_addr [3];
    logic [31:0] b2b_data [3];
    logic        b2b_err  [3];
    b2b_addr = '{32'h0000_1000, 32'h0000_2000, 32'h0000_3000};
    b2b_data = '{32'h1111_2222, 32'h1234_5678, 32'hCAFE_F00D};
    b2b_err  = '{1'b0, 1'b0, 1'b1};

    wait_cfg = '{0, 0, 3, 0};
    rd_val   = '{32'hA5A5_A5A5, 32'h1111_2222, 32'h1234_5678, 32'hCAFE_F00D};
    err_cfg  = 4'b1001;        // unselected slaves 0/3 shout errors during slave 1/2 tests
    req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0;
    req_valid3 = 0; req_addr3 = 0;
    PRESET = 1'b1;
    repeat (2) @(posedge PCLK);
    #1;

    // Reset state
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_psel",      PSEL, 0);
    chk("rst_penable",   PENABLE, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_paddr",     PADDR, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    PRESET = 1'b0;
    @(posedge PCLK); #1;

    // Zero-wait write to slave 1
    issue(1'b1, 32'h0000_1004, 32'hDEAD_BEEF);
    chk("wr_setup_psel",    PSEL, 4'b0010);
    chk("wr_setup_penable", PENABLE, 0);
    chk("wr_setup_paddr",   PADDR, 32'h0000_1004);
    chk("wr_setup_pwrite",  PWRITE, 1);
    chk("wr_setup_pwdata",  PWDATA, 32'hDEAD_BEEF);
    chk("wr_setup_ready",   req_ready, 0);
    @(posedge PCLK); #1;
    chk("wr_access_psel",    PSEL, 4'b0010);
    chk("wr_access_penable", PENABLE, 1);
    chk("wr_access_paddr",   PADDR, 32'h0000_1004);
    @(posedge PCLK); #1;
    chk("wr_rsp_valid", rsp_valid, 1);
    chk("wr_rsp_err",   rsp_err, 0);
    chk("wr_rsp_rdata", rsp_rdata, 0);
    chk("wr_done_psel", PSEL, 0);
    chk("wr_done_pen",  PENABLE, 0);
    @(posedge PCLK); #1;
    chk("wr_after_valid", rsp_valid, 0);
    chk("wr_after_ready", req_ready, 1);

    // Read from slave 2 with 3 wait states
    issue(1'b0, 32'h0000_2010, 32'h0);
    wait_rsp(20, cyc);
    chk("rd3w_latency", cyc, 6);
    chk("rd3w_rdata",   rsp_rdata, 32'h1234_5678);
    chk("rd3w_err",     rsp_err, 0);
    @(posedge PCLK); #1;
    chk("rd3w_hold_valid", rsp_valid, 0);
    chk("rd3w_hold_rdata", rsp_rdata, 32'h1234_5678);

    // Timeout on slave 0 (other slaves have PREADY tied high and must be ignored)
    wait_cfg[0] = -1;
    issue(1'b0, 32'h0000_0020, 32'h0);
    cyc = 1; pen = 0;
    while (rsp_valid !== 1'b1 && cyc < 40) begin
      if (PENABLE) pen++;
      @(posedge PCLK); #1;
      cyc++;
    end
    chk("to_rsp_valid",   rsp_valid, 1);
    chk("to_penable_cyc", pen, 16);
    chk("to_latency",     cyc, 18);
    chk("to_err",         rsp_err, 1);
    chk("to_rdata",       rsp_rdata, 0);
    chk("to_err_count",   err_count, 1);
    @(posedge PCLK); #1;

    // PSLVERR on slave 3 read
    issue(1'b0, 32'h0000_3000, 32'h0);
    wait_rsp(10, cyc);
    chk("slverr_latency",   cyc, 3);
    chk("slverr_err",       rsp_err, 1);
    chk("slverr_rdata",     rsp_rdata, 32'hCAFE_F00D);
    chk("slverr_err_count", err_count, 2);
    @(posedge PCLK); #1;

    // Decode error on the 3-slave build: index 3 has no slave
    chk("dec_ready_before", req_ready3, 1);
    req_valid3 = 1'b1; req_addr3 = 32'h0000_3000;
    @(posedge PCLK); #1;
    req_valid3 = 1'b0;
    chk("dec_rsp_valid", rsp_valid3, 1);
    chk("dec_rsp_err",   rsp_err3, 1);
    chk("dec_rdata",     rsp_rdata3, 0);
    chk("dec_psel",      PSEL3, 0);
    chk("dec_penable",   PENABLE3, 0);
    chk("dec_err_count", err_count3, 1);
    @(posedge PCLK); #1;
    chk("dec_after_valid", rsp_valid3, 0);
    chk("dec_after_ready", req_ready3, 1);

    // Back-to-back with req_valid held high
    wait_cfg[2] = 0;
    nacc = 0; nrsp = 0; last_acc = 0; cyc = 0;
    req_write = 1'b0; req_addr = b2b_addr[0]; req_valid = 1'b1;
    while ((nacc < 3 || nrsp < 3) && cyc < 60) begin
      was_rdy = req_ready;
      @(posedge PCLK); #1;
      cyc++;
      if (was_rdy && req_valid) begin
        if (nacc > 0) chk("b2b_accept_gap", cyc - last_acc, 4);
        last_acc = cyc;
        nacc++;
        if (nacc == 3) req_valid = 1'b0;
        else           req_addr = b2b_addr[nacc];
      end
      if (rsp_valid && nrsp < 3) begin
        chk("b2b_rdata", rsp_rdata, b2b_data[nrsp]);
        chk("b2b_err",   rsp_err,   b2b_err[nrsp]);
        nrsp++;
      end
    end
    req_valid = 1'b0;
    chk("b2b_accepts",   nacc, 3);
    chk("b2b_responses", nrsp, 3);
    chk("b2b_err_count", err_count, 3);
    @(posedge PCLK); #1;

    // 260 further slave errors: count saturates at 255
    nacc = 0; nrsp = 0; cyc = 0;
    req_addr = 32'h0000_3000; req_valid = 1'b1;
    while (nrsp < 260 && cyc < 2000) begin
      was_rdy = req_ready;
      @(posedge PCLK); #1;
      cyc++;
      if (was_rdy && req_valid) begin
        nacc++;
        if (nacc == 260) req_valid = 1'b0;
      end
      if (rsp_valid) begin
        nrsp++;
        if (nrsp == 251) chk("sat_at_254", err_count, 8'd254);
        if (nrsp == 252) chk("sat_at_255", err_count, 8'd255);
      end
    end
    req_valid = 1'b0;
    chk("sat_responses", nrsp, 260);
    chk("sat_final",     err_count, 8'd255);
    @(posedge PCLK); #1;

    // Reset during ACCESS
    wait_cfg[2] = -1;
    issue(1'b0, 32'h0000_2000, 32'h0);
    @(posedge PCLK); #1;
    chk("rstmid_in_access", PENABLE, 1);
    PRESET = 1'b1;
    @(posedge PCLK); #1;
    PRESET = 1'b0;
    chk("rstmid_psel",      PSEL, 0);
    chk("rstmid_penable",   PENABLE, 0);
    chk("rstmid_rsp_valid", rsp_valid, 0);
    chk("rstmid_ready",     req_ready, 1);
    chk("rstmid_err_count", err_count, 0);
    any_rsp = 0;
    repeat (5) begin
      @(posedge PCLK); #1;
      if (rsp_valid) any_rsp++;
    end
    chk("rstmid_no_rsp", any_rsp, 0);
    issue(1'b0, 32'h0000_1008, 32'h0);
    wait_rsp(10, cyc);
    chk("post_rst_latency", cyc, 3);
    chk("post_rst_rdata",   rsp_rdata, 32'h1111_2222);
    chk("post_rst_err",     rsp_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
